wb_arb2_rr: RTL and testbench
=============================

WB_ARB2_RR -- requirements
Module: wb_arb2_rr

Interface
REQ-001 SHALL have parameter `timeout`, default 255: watchdog limit in clk cycles, 1..65535; 0 disables the watchdog.
REQ-002 SHALL have port `clk`, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports `mN_adr_i`, input, 32 bits, for N = 0, 1: master N address.
REQ-005 SHALL have ports `mN_dat_i`, input, 32 bits: master N write data.
REQ-006 SHALL have ports `mN_dat_o`, output, 32 bits: read data to master N.
REQ-007 SHALL have ports `mN_sel_i`, input, 4 bits: master N byte selects.
REQ-008 SHALL have ports `mN_we_i`, `mN_cyc_i` and `mN_stb_i`, each input, 1 bit: master N Wishbone controls.
REQ-009 SHALL have ports `mN_ack_o` and `mN_err_o`, each output, 1 bit: master N acknowledge and bus error.
REQ-010 SHALL have slave-side ports `s_adr_o` (32), `s_dat_o` (32), `s_sel_o` (4), `s_we_o`, `s_cyc_o` and `s_stb_o` (1 each), all outputs: arbitrated request to the shared slave.
REQ-011 SHALL have slave-side ports `s_dat_i` (32) and `s_ack_i` (1), both inputs: slave response.
REQ-012 SHALL have port `gnt_o`, output, 2 bits: one-hot current owner; 00 = idle.

Function
REQ-013 SHALL implement a state machine with states IDLE, GNT0 and GNT1; `gnt_o` SHALL be 00, 01 or 10 in those states respectively.
REQ-014 In IDLE, if only mN_cyc_i is high, the block SHALL enter GNTN on the next edge (1-cycle arbitration latency).
REQ-015 In IDLE, if both cyc inputs are high, the block SHALL grant the master that does not match the `last` register; `last` SHALL reset to 1, so m0 wins the first contention.
REQ-016 On entering GNTN, `last` SHALL be set to N.
REQ-017 The grant SHALL be held while the owner's cyc stays high, regardless of the other master's requests (cycle-atomic: no preemption mid-cycle or mid-burst).
REQ-018 When the owner's cyc is low in GNTN: if the other master's cyc is high, the block SHALL go directly to the other GNT state on the next edge; otherwise it SHALL go to IDLE.
REQ-019 In GNTN, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o and s_stb_o SHALL combinationally follow master N's inputs.
REQ-020 In IDLE, s_cyc_o, s_stb_o and s_we_o SHALL be 0; s_adr_o, s_dat_o and s_sel_o SHALL be 0.
REQ-021 mN_ack_o SHALL equal s_ack_i AND (owner == N); the non-owner SHALL see ack = 0.
REQ-022 s_dat_i SHALL be broadcast to both mN_dat_o without gating.
REQ-023 The watchdog counter (16 bits) SHALL increment each cycle in which the owner's stb is high and s_ack_i is low.
REQ-024 The watchdog counter SHALL clear on s_ack_i, on owner stb low, and on any grant change.
REQ-025 When the watchdog count equals `timeout` (timeout ≠ 0), the owner's mN_err_o SHALL pulse high for exactly 1 cycle and the counter SHALL clear that cycle.
REQ-026 During the cycle of an err pulse, s_stb_o SHALL be forced to 0.
REQ-027 The grant SHALL be retained after a timeout until the owner drops cyc.
REQ-028 If s_ack_i and the timeout coincide in the same cycle, ack SHALL win: no err, and the counter clears.
REQ-029 The non-owner's err output SHALL always be 0.
REQ-030 A master whose cyc drops and rises again while the other master is waiting SHALL NOT regain the bus before the waiting master is served.

Reset
REQ-031 While reset is high at a clk edge: state → IDLE, `last` → 1, watchdog → 0.
REQ-032 Consequently, in the cycle after reset: gnt_o = 00, s_cyc_o = s_stb_o = 0, and all ack/err outputs = 0.
REQ-033 Reset asserted mid-transfer SHALL abort ownership on that edge; a late s_ack_i arriving after reset SHALL be routed to neither master.

Verification
REQ-034 Bench SHALL cover single master: m0 cyc/stb with adr 0x20000000 after reset → gnt_o = 01 one cycle later; s_adr_o = 0x20000000; slave ack → m0_ack_o = 1, m1_ack_o = 0.
REQ-035 Bench SHALL cover simultaneous request: m0 and m1 raise cyc in the same cycle after reset → m0 granted first; when m0 drops cyc, gnt_o = 10 on the next edge with no IDLE cycle.
REQ-036 Bench SHALL cover fairness: both masters request continuously, each dropping cyc after 1 ack → grants alternate 01, 10, 01, 10.
REQ-037 Bench SHALL cover timeout: timeout = 4, owner stb high, slave never acks → mN_err_o high exactly in the 5th granted-stb cycle with s_stb_o = 0 that cycle; no err once timeout is set to 0.
REQ-038 Bench SHALL cover ack/timeout collision: ack arrives in the same cycle the count reaches `timeout` → ack = 1, err = 0, counter cleared.
REQ-039 Bench SHALL cover reset mid-cycle: reset pulsed while GNT1 waits for ack → next cycle gnt_o = 00; a subsequent s_ack_i produces no mN_ack_o.

Source files
------------

// File: rtl/wb_arb2_rr_if.sv
// rtl/wb_arb2_rr_if.sv - two-master Wishbone bus bundle around the round-robin arbiter
interface wb_arb2_rr_if;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic [3:0]  m0_sel_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m1_sel_i;
    logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [1:0]  gnt_o;

    // arbiter view
    modport slave (
        input  m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        input  m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        input  s_dat_i, s_ack_i,
        output m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, gnt_o
    );

    // masters plus shared slave, as seen from outside the arbiter
    modport master (
        output m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        output m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        output s_dat_i, s_ack_i,
        input  m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, gnt_o
    );
endinterface

// File: rtl/wb_arb2_rr.sv
// rtl/wb_arb2_rr.sv - two-master Wishbone round-robin arbiter with cycle-atomic grants and watchdog
module wb_arb2_rr #(
    parameter int unsigned timeout = 255
) (
    input  logic          clk,
    input  logic          reset,
    wb_arb2_rr_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;

    localparam logic [15:0] wdog_limit = 16'(timeout);
    localparam bit          wdog_en    = (timeout != 0);

    state_t      state, state_next;
    logic        last;
    logic [15:0] wdog, wdog_next;
    logic        owner_stb, wdog_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            wdog  <= 16'd0;
        end else begin
            state <= state_next;
            wdog  <= wdog_next;
            if (state_next != state && state_next != IDLE)
                last <= (state_next == GNT1);
        end
    end

    // Owner keeps the bus for as long as its cyc stays high; hand-over skips IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) state_next = last ? GNT0 : GNT1;
                else if (bus.m0_cyc_i)            state_next = GNT0;
                else if (bus.m1_cyc_i)            state_next = GNT1;
            end
            GNT0: if (!bus.m0_cyc_i) state_next = bus.m1_cyc_i ? GNT1 : IDLE;
            GNT1: if (!bus.m1_cyc_i) state_next = bus.m0_cyc_i ? GNT0 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.s_adr_o = 32'd0;
        bus.s_dat_o = 32'd0;
        bus.s_sel_o = 4'd0;
        bus.s_we_o  = 1'b0;
        bus.s_cyc_o = 1'b0;
        owner_stb   = 1'b0;
        if (state == GNT0) begin
            bus.s_adr_o = bus.m0_adr_i;
            bus.s_dat_o = bus.m0_dat_i;
            bus.s_sel_o = bus.m0_sel_i;
            bus.s_we_o  = bus.m0_we_i;
            bus.s_cyc_o = bus.m0_cyc_i;
            owner_stb   = bus.m0_stb_i;
        end else if (state == GNT1) begin
            bus.s_adr_o = bus.m1_adr_i;
            bus.s_dat_o = bus.m1_dat_i;
            bus.s_sel_o = bus.m1_sel_i;
            bus.s_we_o  = bus.m1_we_i;
            bus.s_cyc_o = bus.m1_cyc_i;
            owner_stb   = bus.m1_stb_i;
        end

        // A late ack in the expiry cycle still completes the transfer normally.
        wdog_hit = wdog_en && owner_stb && !bus.s_ack_i && (wdog == wdog_limit);

        if (state_next != state || !owner_stb || bus.s_ack_i || wdog_hit)
            wdog_next = 16'd0;
        else
            wdog_next = wdog + 16'd1;

        bus.s_stb_o  = owner_stb && !wdog_hit;
        bus.m0_ack_o = bus.s_ack_i && (state == GNT0);
        bus.m1_ack_o = bus.s_ack_i && (state == GNT1);
        bus.m0_err_o = wdog_hit && (state == GNT0);
        bus.m1_err_o = wdog_hit && (state == GNT1);
        bus.m0_dat_o = bus.s_dat_i;
        bus.m1_dat_o = bus.s_dat_i;
        bus.gnt_o    = state;
    end
endmodule

// File: tb/tb_wb_arb2_rr.sv
// tb/tb_wb_arb2_rr.sv - scoreboard bench for the two-master round-robin arbiter
module tb_wb_arb2_rr;
    typedef struct packed {
        bit rst, c0, s0, c1, s1, ack;
        bit [1:0] gnt;
        bit a0, a1, e0, e1, sstb;
    } vec_t;

    typedef struct packed {
        bit [1:0]  gnt;
        bit        scyc, sstb, a0, a1, e0, e1, ez;
        bit [3:0]  sel;
        bit [31:0] adr, dat0, dat1;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];
    obs_t exp_q[$];
    int   idx_q[$];

    wb_arb2_rr_if bus ();
    wb_arb2_rr_if bus_z ();

    wb_arb2_rr #(.timeout(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    wb_arb2_rr #(.timeout(0)) dut_z (.clk(clk), .reset(reset), .bus(bus_z));

    assign bus_z.m0_adr_i = bus.m0_adr_i;
    assign bus_z.m0_dat_i = bus.m0_dat_i;
    assign bus_z.m0_sel_i = bus.m0_sel_i;
    assign bus_z.m0_we_i  = bus.m0_we_i;
    assign bus_z.m0_cyc_i = bus.m0_cyc_i;
    assign bus_z.m0_stb_i = bus.m0_stb_i;
    assign bus_z.m1_adr_i = bus.m1_adr_i;
    assign bus_z.m1_dat_i = bus.m1_dat_i;
    assign bus_z.m1_sel_i = bus.m1_sel_i;
    assign bus_z.m1_we_i  = bus.m1_we_i;
    assign bus_z.m1_cyc_i = bus.m1_cyc_i;
    assign bus_z.m1_stb_i = bus.m1_stb_i;
    assign bus_z.s_dat_i  = bus.s_dat_i;
    assign bus_z.s_ack_i  = bus.s_ack_i;

    always #5 clk = ~clk;

    task automatic add(input bit rst, c0, s0, c1, s1, ack, input bit [1:0] gnt,
                       input bit a0, a1, e0, e1, sstb);
        vec_t v;
        v = '{rst, c0, s0, c1, s1, ack, gnt, a0, a1, e0, e1, sstb};
        vecs.push_back(v);
    endtask

    task automatic build_vectors();
        // single master m0
        add(0, 0,0, 0,0, 0, 2'b00, 0,0, 0,0, 0);
        add(0, 1,1, 0,0, 0, 2'b00, 0,0, 0,0, 0);
        add(0, 1,1, 0,0, 0, 2'b01, 0,0, 0,0, 1);
        add(0, 1,1, 0,0, 1, 2'b01, 1,0, 0,0, 1);
        add(0, 0,0, 0,0, 0, 2'b01, 0,0, 0,0, 0);
        add(0, 0,0, 0,0, 0, 2'b00, 0,0, 0,0, 0);
        // simultaneous request after reset, direct hand-over
        add(1, 0,0, 0,0, 0, 2'b00, 0,0, 0,0, 0);
        add(0, 1,1, 1,1, 0, 2'b00, 0,0, 0,0, 0);
        add(0, 1,1, 1,1, 0, 2'b01, 0,0, 0,0, 1);
        add(0, 1,1, 1,1, 1, 2'b01, 1,0, 0,0, 1);
        add(0, 0,0, 1,1, 0, 2'b01, 0,0, 0,0, 0);
        add(0, 0,0, 1,1, 0, 2'b10, 0,0, 0,0, 1);
        add(0, 0,0, 1,1, 1, 2'b10, 0,1, 0,0, 1);
        add(0, 0,0, 0,0, 0, 2'b10, 0,0, 0,0, 0);
        add(0, 0,0, 0,0, 0, 2'b00, 0,0, 0,0, 0);
        // fairness under continuous demand, m0 re-raises while m1 owns
        add(0, 1,1, 1,1, 0, 2'b00, 0,0, 0,0, 0);
        add(0, 1,1, 1,1, 1, 2'b01, 1,0, 0,0, 1);
        add(0, 0,0, 1,1, 0, 2'b01, 0,0, 0,0, 0);
        add(0, 1,1, 1,1, 1, 2'b10, 0,1, 0,0, 1);
        add(0, 1,1, 0,0, 0, 2'b10, 0,0, 0,0, 0);
        add(0, 1,1, 1,1, 1, 2'b01, 1,0, 0,0, 1);
        add(0, 0,0, 1,1, 0, 2'b01, 0,0, 0,0, 0);
        add(0, 1,1, 1,1, 1, 2'b10, 0,1, 0,0, 1);
        add(0, 0,0, 0,0, 0, 2'b10, 0,0, 0,0, 0);
        add(0, 0,0, 0,0, 0, 2'b00, 0,0, 0,0, 0);
        // timeout = 4: err in 5th granted-stb cycle, grant retained
        add(0, 1,1, 0,0, 0, 2'b00, 0,0, 0,0, 0);
        for (int i = 0; i < 4; i++) add(0, 1,1, 0,0, 0, 2'b01, 0,0, 0,0, 1);
        add(0, 1,1, 0,0, 0, 2'b01, 0,0, 1,0, 0);
        add(0, 1,1, 0,0, 0, 2'b01, 0,0, 0,0, 1);
        add(0, 0,0, 0,0, 0, 2'b01, 0,0, 0,0, 0);
        add(0, 0,0, 0,0, 0, 2'b00, 0,0, 0,0, 0);
        // ack coincides with expiry, counter restarts from zero
        add(0, 1,1, 0,0, 0, 2'b00, 0,0, 0,0, 0);
        for (int i = 0; i < 4; i++) add(0, 1,1, 0,0, 0, 2'b01, 0,0, 0,0, 1);
        add(0, 1,1, 0,0, 1, 2'b01, 1,0, 0,0, 1);
        for (int i = 0; i < 4; i++) add(0, 1,1, 0,0, 0, 2'b01, 0,0, 0,0, 1);
        add(0, 1,1, 0,0, 0, 2'b01, 0,0, 1,0, 0);
        add(0, 0,0, 0,0, 0, 2'b01, 0,0, 0,0, 0);
        add(0, 0,0, 0,0, 0, 2'b00, 0,0, 0,0, 0);
        // reset while m1 waits for ack, then a stray ack
        add(0, 0,0, 1,1, 0, 2'b00, 0,0, 0,0, 0);
        add(0, 0,0, 1,1, 0, 2'b10, 0,0, 0,0, 1);
        add(1, 0,0, 1,1, 0, 2'b10, 0,0, 0,0, 1);
        add(0, 0,0, 0,0, 1, 2'b00, 0,0, 0,0, 0);
        add(0, 0,0, 0,0, 0, 2'b00, 0,0, 0,0, 0);
    endtask

    function automatic obs_t expect_of(input vec_t v, input bit [31:0] sdat);
        obs_t e;
        e = '0;
        e.gnt  = v.gnt;
        e.sstb = v.sstb;
        e.a0 = v.a0; e.a1 = v.a1; e.e0 = v.e0; e.e1 = v.e1;
        e.ez = 1'b0;
        e.dat0 = sdat;
        e.dat1 = sdat;
        if (v.gnt == 2'b01) begin
            e.scyc = v.c0; e.adr = 32'h2000_0000; e.sel = 4'h3;
        end else if (v.gnt == 2'b10) begin
            e.scyc = v.c1; e.adr = 32'h3000_0004; e.sel = 4'hC;
        end
        return e;
    endfunction

    initial begin
        bit [31:0] sdat;
        reset = 1'b1;
        bus.m0_adr_i = 32'h2000_0000; bus.m0_dat_i = 32'h1111_0000;
        bus.m0_sel_i = 4'h3;          bus.m0_we_i  = 1'b1;
        bus.m1_adr_i = 32'h3000_0004; bus.m1_dat_i = 32'h2222_0000;
        bus.m1_sel_i = 4'hC;          bus.m1_we_i  = 1'b0;
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        bus.s_ack_i = 0;  bus.s_dat_i = 32'd0;
        build_vectors();
        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            sdat = 32'hA500_0000 | 32'(i);
            reset        = vecs[i].rst;
            bus.m0_cyc_i = vecs[i].c0;
            bus.m0_stb_i = vecs[i].s0;
            bus.m1_cyc_i = vecs[i].c1;
            bus.m1_stb_i = vecs[i].s1;
            bus.s_ack_i  = vecs[i].ack;
            bus.s_dat_i  = sdat;
            exp_q.push_back(expect_of(vecs[i], sdat));
            idx_q.push_back(i);
        end
        @(posedge clk);
        #1;
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        bus.s_ack_i = 0;
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses left unchecked, need 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e, a;
            int   idx;
            e = exp_q.pop_front();
            idx = idx_q.pop_front();
            a.gnt  = bus.gnt_o;
            a.scyc = bus.s_cyc_o;
            a.sstb = bus.s_stb_o;
            a.a0   = bus.m0_ack_o;
            a.a1   = bus.m1_ack_o;
            a.e0   = bus.m0_err_o;
            a.e1   = bus.m1_err_o;
            a.ez   = bus_z.m0_err_o | bus_z.m1_err_o;
            a.sel  = bus.s_sel_o;
            a.adr  = bus.s_adr_o;
            a.dat0 = bus.m0_dat_o;
            a.dat1 = bus.m1_dat_o;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL row%0d: got gnt=%b cyc=%b stb=%b ack=%b%b err=%b%b errz=%b sel=%h adr=%h dat=%h/%h need gnt=%b cyc=%b stb=%b ack=%b%b err=%b%b errz=%b sel=%h adr=%h dat=%h/%h",
                         idx, a.gnt, a.scyc, a.sstb, a.a0, a.a1, a.e0, a.e1, a.ez, a.sel, a.adr, a.dat0, a.dat1,
                         e.gnt, e.scyc, e.sstb, e.a0, e.a1, e.e0, e.e1, e.ez, e.sel, e.adr, e.dat0, e.dat1);
            end
        end
    end
endmodule
